// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502 cycle sequencer: sequencer states, vectors, BRK opcode.
// SEQ_JAM_EN (optional) enables the JAM-opcode lockup state in cpu_cycle_sequencer.
package cpu_pkg;

    typedef enum logic [1:0] {
        RESET_SEQ = 2'd0,
        RUN       = 2'd1,
        INT_SEQ   = 2'd2,
        JAM       = 2'd3
    } seq_state_t;

    localparam logic [15:0] DEF_VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] DEF_VEC_RESET = 16'hFFFC;
    localparam logic [15:0] DEF_VEC_IRQ   = 16'hFFFE;
    localparam logic [7:0]  OP_BRK        = 8'h00;

    // x2 opcodes that halt the NMOS 6502: 02..72 plus 92, B2, D2, F2
    function automatic logic is_jam_op(input logic [7:0] op);
        logic hi_ok;
        hi_ok = (op[7:4] <= 4'h7) || (op[7:4] == 4'h9) || (op[7:4] == 4'hB) ||
                (op[7:4] == 4'hD) || (op[7:4] == 4'hF);
        return (op[3:0] == 4'h2) && hi_ok;
    endfunction

endpackage

// File: rtl/cpu_cycle_sequencer_nmi_edge_latch.sv
// NMI falling-edge detector with a pending flag that holds until the vector is committed.
module nmi_edge_latch (
    input  logic clk_ph1,
    input  logic rst,
    input  logic nmi_n,
    input  logic clear,
    output logic pending
);

    logic nmi_prev_r;
    logic pending_r;
    logic edge_s;

    assign edge_s  = nmi_prev_r & ~nmi_n;
    assign pending = pending_r;

    // A fresh edge wins over a same-cycle clear so no request is lost
    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            nmi_prev_r <= 1'b1;
            pending_r  <= 1'b0;
        end else begin
            nmi_prev_r <= nmi_n;
            if (edge_s) begin
                pending_r <= 1'b1;
            end else if (clear) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Cycle-counter sequencer: inc/res generation, interrupt polling, forced BRK and vector select.
// Define SEQ_JAM_EN to lock the sequencer on JAM opcodes until reset.
module cpu_cycle_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] VEC_NMI      = DEF_VEC_NMI,
    parameter logic [15:0] VEC_RESET    = DEF_VEC_RESET,
    parameter logic [15:0] VEC_IRQ      = DEF_VEC_IRQ,
    parameter int unsigned HIJACK_CYCLE = 4
)(
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [7:0]  IR,
    input  logic [2:0]  cycle,
    input  logic        last_cycle,
    input  logic        rw,
    input  logic        rdy,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    output logic        inc_cycle,
    output logic        res_cycle,
    output logic        force_brk,
    output logic [15:0] vec_addr,
    output logic        int_active,
    output logic        suppress_write,
    output logic        b_flag_push,
    output logic        sync
);

    localparam logic [2:0] HIJACK_CYC = 3'(HIJACK_CYCLE);

    seq_state_t  state_r, state_nxt_s;
    logic [15:0] vec_r, vec_nxt_s;
    logic        hijack_r, hijack_nxt_s;
    logic        nmi_pending_s;
    logic        nmi_clear_s;
    logic        stall_s;
    logic        brk_irq_s;
    logic        hijack_now_s;
    logic        hijack_s;
    logic        jam_hit_s;

    nmi_edge_latch u_nmi (
        .clk_ph1 (clk_ph1),
        .rst     (rst),
        .nmi_n   (nmi_n),
        .clear   (nmi_clear_s),
        .pending (nmi_pending_s)
    );

    assign stall_s = ~rdy & rw;

    // A BRK sequence heading for the IRQ vector: software BRK in RUN, or a hardware IRQ
    assign brk_irq_s = ((state_r == RUN) && (IR == OP_BRK) && (cycle != 3'd0)) ||
                       ((state_r == INT_SEQ) && (vec_r == VEC_IRQ));
    assign hijack_now_s = brk_irq_s && nmi_pending_s && (cycle == HIJACK_CYC) && !hijack_r;
    assign hijack_s     = hijack_r | hijack_now_s;

`ifdef SEQ_JAM_EN
    assign jam_hit_s = (state_r == RUN) && (cycle == 3'd1) && is_jam_op(IR);
`else
    assign jam_hit_s = 1'b0;
`endif

    // Next state: hijack commit, boundary polling, jam entry; stalls freeze everything
    always_comb begin
        state_nxt_s  = state_r;
        vec_nxt_s    = vec_r;
        hijack_nxt_s = hijack_r;
        nmi_clear_s  = 1'b0;
        if (jam_hit_s) begin
            state_nxt_s = JAM;
        end else if (stall_s) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                RESET_SEQ: begin
                    if (last_cycle) begin
                        state_nxt_s  = RUN;
                        vec_nxt_s    = VEC_IRQ;
                        hijack_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = RESET_SEQ;
                    end
                end
                RUN, INT_SEQ: begin
                    if (hijack_now_s) begin
                        hijack_nxt_s = 1'b1;
                        nmi_clear_s  = 1'b1;
                    end else begin
                        hijack_nxt_s = hijack_r;
                    end
                    // A hijack at this same cycle already consumed the pending NMI
                    if (last_cycle) begin
                        hijack_nxt_s = 1'b0;
                        if (nmi_pending_s && !hijack_now_s) begin
                            state_nxt_s = INT_SEQ;
                            vec_nxt_s   = VEC_NMI;
                            nmi_clear_s = 1'b1;
                        end else if (!irq_n && !i_flag) begin
                            state_nxt_s = INT_SEQ;
                            vec_nxt_s   = VEC_IRQ;
                        end else begin
                            state_nxt_s = RUN;
                            vec_nxt_s   = VEC_IRQ;
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                JAM: begin
                    state_nxt_s = JAM;
                end
                default: begin
                    state_nxt_s = RESET_SEQ;
                end
            endcase
        end
    end

    // State, committed vector and hijack flag
    always_ff @(posedge clk_ph1) begin
        if (rst) begin
            state_r  <= RESET_SEQ;
            vec_r    <= VEC_RESET;
            hijack_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            vec_r    <= vec_nxt_s;
            hijack_r <= hijack_nxt_s;
        end
    end

    // Outputs from registered state plus live inputs; reset overrides everything
    always_comb begin
        inc_cycle      = 1'b0;
        res_cycle      = 1'b0;
        force_brk      = 1'b0;
        vec_addr       = VEC_IRQ;
        int_active     = 1'b0;
        suppress_write = 1'b0;
        b_flag_push    = 1'b0;
        sync           = 1'b0;
        if (rst) begin
            res_cycle      = 1'b1;
            force_brk      = 1'b1;
            vec_addr       = VEC_RESET;
            int_active     = 1'b1;
            suppress_write = 1'b1;
        end else begin
            case (state_r)
                RESET_SEQ: begin
                    force_brk      = (cycle == 3'd0);
                    vec_addr       = VEC_RESET;
                    int_active     = 1'b1;
                    suppress_write = 1'b1;
                end
                RUN: begin
                    b_flag_push = 1'b1;
                    vec_addr    = hijack_s ? VEC_NMI : VEC_IRQ;
                end
                INT_SEQ: begin
                    force_brk  = (cycle == 3'd0);
                    int_active = 1'b1;
                    vec_addr   = hijack_s ? VEC_NMI : vec_r;
                end
                JAM: begin
                    vec_addr = VEC_IRQ;
                end
                default: begin
                    vec_addr = VEC_IRQ;
                end
            endcase
            if ((state_r == JAM) || jam_hit_s) begin
                inc_cycle = 1'b0;
                res_cycle = 1'b0;
            end else if (stall_s) begin
                inc_cycle = 1'b0;
                res_cycle = 1'b0;
            end else begin
                res_cycle = last_cycle;
                inc_cycle = ~last_cycle;
                sync      = (cycle == 3'd0) && (state_r != RESET_SEQ);
            end
        end
    end

endmodule
